// File: rtl/dcache_assoc.sv
// N-way set-associative write-back data cache between dbus and cbus, round-robin victims.
// Optional DCACHE_PERF_EN adds saturating hit/miss/writeback counters.
package dcache_assoc_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1} mburst_t;
  localparam logic [7:0] MLEN1 = 8'd0;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    mburst_t     burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int         WAYS         = 2,
  parameter int         OFFSET_BITS  = 6,
  parameter int         INDEX_BITS   = 6,
  parameter logic [3:0] CACHE_REGION = 4'h8
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output cbus_req_t   creq,
  input  cbus_resp_t  cresp
`ifdef DCACHE_PERF_EN
  ,
  output logic [63:0] hit_cnt,
  output logic [63:0] miss_cnt,
  output logic [63:0] wb_cnt
`endif
);
  localparam int WW    = OFFSET_BITS - 3;
  localparam int WORDS = 1 << WW;
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAGW  = 28 - OFFSET_BITS - INDEX_BITS;
  localparam int RRW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [7:0] LINE_LEN = 8'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_UNCACHED} state_t;

  state_t           r_state, w_state_n;
  logic [WW-1:0]    r_cnt;
  logic [RRW-1:0]   r_victim;
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [RRW-1:0]   r_rr    [SETS];
  logic [TAGW-1:0]  r_tag   [WAYS][SETS];
  logic [63:0]      r_data  [WAYS][SETS][WORDS];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAGW-1:0]       w_tag;
  logic [WW-1:0]         w_word;
  logic                  w_cacheable;
  logic                  w_hit, w_inv_found;
  logic [RRW-1:0]        w_hit_way, w_inv_way, w_victim;
  logic                  w_store_hit, w_miss, w_beat, w_fill_done, w_wb_done;

  assign w_idx       = dreq.addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_tag       = dreq.addr[27:OFFSET_BITS+INDEX_BITS];
  assign w_word      = dreq.addr[OFFSET_BITS-1:3];
  assign w_cacheable = (dreq.addr[63:32] == 32'b0) && (dreq.addr[31:28] == CACHE_REGION);

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = RRW'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = RRW'(w);
      end
    end
  end

  assign w_victim    = w_inv_found ? w_inv_way : r_rr[w_idx];
  assign w_beat      = ((r_state == S_WRITEBACK) || (r_state == S_FETCH)) && cresp.ready;
  assign w_fill_done = (r_state == S_FETCH) && cresp.ready && cresp.last;
  assign w_wb_done   = (r_state == S_WRITEBACK) && cresp.ready && cresp.last;

  always_comb begin
    w_state_n     = r_state;
    dresp         = '0;
    dresp.addr_ok = 1'b1;
    creq          = '0;
    w_store_hit   = 1'b0;
    w_miss        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dreq.valid) begin
          if (!w_cacheable) begin
            w_state_n = S_UNCACHED;
          end else if (w_hit) begin
            dresp.data_ok = 1'b1;
            dresp.data    = r_data[w_hit_way][w_idx][w_word];
            w_store_hit   = |dreq.strobe;
          end else begin
            w_miss    = 1'b1;
            w_state_n = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.size     = MSIZE8;
        creq.strobe   = '1;
        creq.len      = LINE_LEN;
        creq.burst    = BURST_INCR;
        creq.addr     = {32'b0, CACHE_REGION, r_tag[r_victim][w_idx], w_idx, {OFFSET_BITS{1'b0}}};
        creq.data     = r_data[r_victim][w_idx][r_cnt];
        if (w_wb_done) w_state_n = S_FETCH;
      end
      S_FETCH: begin
        creq.valid = 1'b1;
        creq.size  = MSIZE8;
        creq.len   = LINE_LEN;
        creq.burst = BURST_INCR;
        creq.addr  = {dreq.addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (w_fill_done) w_state_n = S_IDLE;
      end
      S_UNCACHED: begin
        creq.valid    = 1'b1;
        creq.is_write = |dreq.strobe;
        creq.size     = dreq.size;
        creq.addr     = dreq.addr;
        creq.strobe   = dreq.strobe;
        creq.data     = dreq.data;
        creq.len      = MLEN1;
        creq.burst    = BURST_FIXED;
        if (cresp.ready) begin
          dresp.data_ok = 1'b1;
          dresp.data    = cresp.data;
          w_state_n     = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_victim <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_state_n;
      if (w_miss)      r_victim <= w_victim;
      if (w_store_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_beat)      r_cnt <= cresp.last ? '0 : r_cnt + 1'b1;
      if (w_fill_done) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
        r_rr[w_idx]              <= (WAYS == 1) ? '0 : r_victim + 1'b1;
      end
    end
  end

  // Tag/data arrays are RAM-like: no reset, contents only meaningful under valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_store_hit) begin
        for (int b = 0; b < 8; b++)
          if (dreq.strobe[b]) r_data[w_hit_way][w_idx][w_word][8*b +: 8] <= dreq.data[8*b +: 8];
      end
      if ((r_state == S_FETCH) && cresp.ready) r_data[r_victim][w_idx][r_cnt] <= cresp.data;
      if (w_fill_done) r_tag[r_victim][w_idx] <= w_tag;
    end
  end

`ifdef DCACHE_PERF_EN
  logic        r_filled;
  logic [63:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_filled   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      // The completion right after a fill is a replay of the miss, not a hit.
      if (w_fill_done) r_filled <= 1'b1;
      else if (dresp.data_ok) r_filled <= 1'b0;
      if ((r_state == S_IDLE) && dresp.data_ok && !r_filled && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 64'd1;
      if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 64'd1;
      if (w_wb_done && (r_wb_cnt != '1)) r_wb_cnt <= r_wb_cnt + 64'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif
endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: flat-memory + set/way reference model, random cbus stalls.
module tb_dcache_assoc;
  import dcache_assoc_pkg::*;

  localparam int WAYS = 2, OB = 6, IB = 6;
  localparam int WORDS = 1 << (OB - 3), SETS = 1 << IB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
`ifdef DCACHE_PERF_EN
  logic [63:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  dcache_assoc #(.WAYS(WAYS), .OFFSET_BITS(OB), .INDEX_BITS(IB), .CACHE_REGION(4'h8)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .creq(creq), .cresp(cresp)
`ifdef DCACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  typedef struct {
    bit          is_load, hit, wb, unc, chk_lat;
    logic [63:0] data, wb_addr, line;
    int          n_wb0, n_fe0, n_un0, cyc0, lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0, n_errors = 0, n_done = 0, cyc = 0;
  int          sl_beat = 0, n_wb = 0, n_fe = 0, n_un = 0;
  logic [63:0] last_wb_addr = '0, last_fe_addr = '0;
  bit          rdy_rand = 1'b0;
  logic [63:0] cur_addr, cur_data;
  logic [7:0]  cur_strb;
  msize_t      cur_size;

  logic [63:0] mem     [longint];
  logic [63:0] ref_mem [longint];
  logic [63:0] m_line  [SETS][WAYS];
  bit          m_v     [SETS][WAYS];
  bit          m_d     [SETS][WAYS];
  int          m_rr    [SETS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input longint k);
    logic [63:0] kk;
    kk = k;
    return {kk[31:0] ^ 32'hC0DE_0000, kk[31:0] * 32'h9E37_79B1};
  endfunction

  function automatic logic [63:0] rdmem(input longint k);
    return mem.exists(k) ? mem[k] : init_word(k);
  endfunction

  function automatic logic [63:0] rdref(input longint k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
        m_line[s][w] = '0;
      end
    end
  endtask

  // Reference: the cache is transparent over ref_mem; the set/way table only predicts traffic.
  task automatic predict(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d, output exp_t e);
    logic [63:0] line;
    longint      wk;
    int          set, hw, v;
    e = '{default: '0};
    wk = longint'(a >> 3);
    if (a[63:32] == 32'b0 && a[31:28] == 4'h8) begin
      line   = a & ~64'(WORDS * 8 - 1);
      set    = int'((a >> OB) % SETS);
      e.line = line;
      hw     = -1;
      for (int i = 0; i < WAYS; i++) if (m_v[set][i] && m_line[set][i] == line) hw = i;
      if (hw < 0) begin
        v = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (!m_v[set][i]) v = i;
        if (v < 0) v = m_rr[set];
        e.wb      = m_v[set][v] && m_d[set][v];
        e.wb_addr = m_line[set][v];
        e.lat     = (e.wb ? WORDS : 0) + WORDS + 1;
        m_line[set][v] = line;
        m_v[set][v]    = 1'b1;
        m_d[set][v]    = 1'b0;
        m_rr[set]      = (v + 1) % WAYS;
        hw = v;
      end else begin
        e.hit = 1'b1;
      end
      if (s != 0) m_d[set][hw] = 1'b1;
    end else begin
      e.unc = 1'b1;
    end
    if (s != 0) ref_mem[wk] = merge(rdref(wk), d, s);
    e.is_load = (s == 0);
    e.data    = rdref(wk);
    e.chk_lat = !rdy_rand;
  endtask

  task automatic finish_run();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  task automatic access(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d, input msize_t sz);
    exp_t e;
    int   done0;
    @(posedge clk); #1;
    predict(a, s, d, e);
    cur_addr = a; cur_strb = s; cur_data = d; cur_size = sz;
    e.cyc0 = cyc; e.n_wb0 = n_wb; e.n_fe0 = n_fe; e.n_un0 = n_un;
    sbq.push_back(e);
    done0 = n_done;
    dreq.valid = 1'b1; dreq.addr = a; dreq.size = sz; dreq.strobe = s; dreq.data = d;
    for (int k = 0; k < 400 && n_done == done0; k++) begin @(posedge clk); #1; end
    if (n_done == done0) begin
      chk("data_ok_timeout", 64'(n_done), 64'(done0 + 1));
      finish_run();
    end
    dreq = '0;
  endtask

  // Memory slave: decides each beat on the falling edge, DUT consumes it on the next rising edge.
  initial begin
    logic [63:0] a;
    longint      k;
    cresp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sl_beat = 0;
        cresp   = '0;
      end else begin
        if (cresp.ready) sl_beat = cresp.last ? 0 : sl_beat + 1;
        cresp = '0;
        if (creq.valid && (!rdy_rand || $urandom_range(0, 3) != 0)) begin
          if (creq.burst == BURST_FIXED) begin
            a = creq.addr;
            n_un++;
            chk("unc_addr", creq.addr, cur_addr);
            chk("unc_ctl", 64'({creq.size, creq.strobe, creq.is_write, creq.len}),
                64'({cur_size, cur_strb, (cur_strb != 8'd0), MLEN1}));
            if (creq.is_write) chk("unc_wdata", creq.data, cur_data);
          end else begin
            a = creq.addr + 64'(sl_beat * 8);
            if (sl_beat == 0) begin
              if (creq.is_write) begin n_wb++; last_wb_addr = creq.addr; end
              else begin n_fe++; last_fe_addr = creq.addr; end
              chk("burst_ctl", 64'({creq.size, creq.len, (creq.is_write ? creq.strobe : 8'hFF)}),
                  64'({MSIZE8, 8'(WORDS - 1), 8'hFF}));
            end
          end
          cresp.ready = 1'b1;
          cresp.last  = (sl_beat == int'(creq.len));
          k = longint'(a >> 3);
          if (creq.is_write) mem[k] = merge(rdmem(k), creq.data, creq.strobe);
          else cresp.data = rdmem(k);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every data_ok pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!reset && dresp.data_ok) begin
        if (sbq.size() == 0) begin
          chk("spurious_data_ok", 64'(dresp.data_ok), 64'd0);
        end else begin
          e = sbq.pop_front();
          if (e.is_load) chk("load_data", dresp.data, e.data);
          chk("fetch_bursts", 64'(n_fe - e.n_fe0), 64'((e.hit || e.unc) ? 0 : 1));
          chk("wb_bursts", 64'(n_wb - e.n_wb0), 64'(e.wb));
          chk("unc_beats", 64'(n_un - e.n_un0), 64'(e.unc));
          if (e.wb) chk("wb_addr", last_wb_addr, e.wb_addr);
          if (!e.hit && !e.unc) chk("fetch_addr", last_fe_addr, e.line);
          if (e.hit) chk("hit_latency", 64'(cyc - e.cyc0 - 1), 64'd0);
          else if (e.chk_lat && !e.unc) chk("miss_latency", 64'(cyc - e.cyc0 - 1), 64'(e.lat));
          n_done++;
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [7:0]  s;
    int          b, r;
    dreq = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #2;
    chk("rst_creq_valid", 64'(creq.valid), 64'd0);
    chk("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    chk("rst_addr_ok", 64'(dresp.addr_ok), 64'd1);

    // Directed scenarios with an always-ready memory so latencies are exact.
    access(64'h8000_0040, 8'h00, '0, MSIZE8);
    access(64'h8000_0040, 8'h0F, 64'h1122_3344_5566_7788, MSIZE8);
    access(64'h8000_0040, 8'h00, '0, MSIZE8);
    access(64'h8000_0000, 8'h00, '0, MSIZE8);
    access(64'h8000_1000, 8'h00, '0, MSIZE8);
    access(64'h8000_2000, 8'h00, '0, MSIZE8);
    access(64'h8000_1000, 8'h00, '0, MSIZE8);
    access(64'h8000_0008, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, MSIZE8);
    access(64'h8000_1000, 8'h00, '0, MSIZE8);
    access(64'h8000_2000, 8'h00, '0, MSIZE8);
    access(64'h8000_3000, 8'h00, '0, MSIZE8);
    access(64'h8000_0008, 8'h00, '0, MSIZE8);
    access(64'h4060_0004, 8'h10, 64'h0000_00AB_0000_0000, MSIZE1);
    access(64'h4060_0000, 8'h00, '0, MSIZE8);
    access(64'h8000_0040, 8'h00, '0, MSIZE8);

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        a = 64'h8000_0000 | (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 3)) << 6)
            | (64'($urandom_range(0, 7)) << 3);
        s = (r < 4) ? 8'($urandom_range(1, 255)) : 8'h00;
        access(a, s, {$urandom, $urandom}, MSIZE8);
      end else if (r == 8) begin
        access(64'h4060_0000 | (64'($urandom_range(0, 3)) << 3), 8'h00, '0, MSIZE8);
      end else begin
        b = $urandom_range(0, 7);
        a = 64'h4060_0000 | (64'($urandom_range(0, 3)) << 3) | 64'(b);
        access(a, 8'(1 << b), 64'($urandom_range(0, 255)) << (8 * b), MSIZE1);
      end
    end

    // Reset in the middle of a line fill.
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_5040; dreq.size = MSIZE8; dreq.strobe = '0; dreq.data = '0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (sl_beat == 3 && creq.valid && !creq.is_write) break;
    end
    chk("fill_beat3_reached", 64'(sl_beat), 64'd3);
    reset = 1'b1;
    dreq  = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #2;
    chk("rst_mid_fill_valid", 64'(creq.valid), 64'd0);
    model_clear();
    ref_mem = mem;
    access(64'h8000_5040, 8'h00, '0, MSIZE8);
    access(64'h8000_0040, 8'h00, '0, MSIZE8);
    access(64'h8000_5048, 8'h00, '0, MSIZE8);

    repeat (3) @(posedge clk);
    finish_run();
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end
endmodule
